// File: rtl/sr_flag_bank_pkg.sv
// Shared types and the set/reset conflict resolution rule for the flag bank.
package sr_pkg;

  typedef enum logic [1:0] {
    CM_RST_DOM = 2'd0,
    CM_SET_DOM = 2'd1,
    CM_HOLD    = 2'd2,
    CM_TOGGLE  = 2'd3
  } conflict_mode_e;

  // Next flag value given the (already hold-masked) set/reset requests.
  function automatic logic resolve(input logic s, input logic r, input logic q,
                                   input conflict_mode_e mode);
    logic nq;
    nq = q;
    if (s && !r) begin
      nq = 1'b1;
    end else if (r && !s) begin
      nq = 1'b0;
    end else if (s && r) begin
      case (mode)
        CM_RST_DOM: nq = 1'b0;
        CM_SET_DOM: nq = 1'b1;
        CM_HOLD:    nq = q;
        CM_TOGGLE:  nq = ~q;
        default:    nq = 1'b0;
      endcase
    end
    return nq;
  endfunction

endpackage

// File: rtl/sr_flag_bank_chan.sv
// One flag channel: registered flag, min-hold guard with deferred reset,
// edge pulses and a sticky conflict bit.
module sr_flag_chan
  import sr_pkg::*;
#(
  parameter conflict_mode_e MODE     = CM_RST_DOM,
  parameter int             MIN_HOLD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_i,
  input  logic r_i,
  input  logic clr_conflict_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic conflict_o,
  output logic conflict_stb_o
);

  localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

  logic [HW-1:0] hold_cnt;
  logic          pend_rst;
  logic          hold_busy;
  logic          eff_r;
  logic          q_next;

  always_comb begin
    hold_busy      = (hold_cnt != '0);
    eff_r          = (r_i | pend_rst) & ~hold_busy;
    q_next         = resolve(s_i, eff_r, q_o, MODE);
    conflict_stb_o = s_i & r_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_o        <= 1'b0;
      rise_o     <= 1'b0;
      fall_o     <= 1'b0;
      conflict_o <= 1'b0;
      hold_cnt   <= '0;
      pend_rst   <= 1'b0;
    end else begin
      q_o    <= q_next;
      rise_o <= q_next & ~q_o;
      fall_o <= ~q_next & q_o;

      if (s_i && r_i) begin
        conflict_o <= 1'b1;
      end else if (clr_conflict_i) begin
        conflict_o <= 1'b0;
      end

      // A reset arriving during the hold window is remembered until the window closes.
      if (MIN_HOLD > 0) begin
        if (q_next && !q_o) begin
          hold_cnt <= HW'(MIN_HOLD);
        end else if (hold_busy) begin
          hold_cnt <= hold_cnt - HW'(1);
        end

        if (s_i && !r_i) begin
          pend_rst <= 1'b0;
        end else if (r_i && hold_busy) begin
          pend_rst <= 1'b1;
        end else if (!q_next) begin
          pend_rst <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of N_CH independent set/reset flags sharing one saturating conflict counter.
module sr_flag_bank
  import sr_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CONFLICT_MODE = 0,
  parameter int MIN_HOLD      = 0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  s_i,
  input  logic [N_CH-1:0]  r_i,
  input  logic [N_CH-1:0]  clr_conflict_i,
  input  logic             clr_cnt_i,
  output logic [N_CH-1:0]  q_o,
  output logic [N_CH-1:0]  qn_o,
  output logic [N_CH-1:0]  rise_o,
  output logic [N_CH-1:0]  fall_o,
  output logic [N_CH-1:0]  conflict_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  localparam conflict_mode_e MODE = conflict_mode_e'(2'(CONFLICT_MODE));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0] conflict_stb;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    sr_flag_chan #(
      .MODE     (MODE),
      .MIN_HOLD (MIN_HOLD)
    ) u_chan (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_i            (s_i[i]),
      .r_i            (r_i[i]),
      .clr_conflict_i (clr_conflict_i[i]),
      .q_o            (q_o[i]),
      .rise_o         (rise_o[i]),
      .fall_o         (fall_o[i]),
      .conflict_o     (conflict_o[i]),
      .conflict_stb_o (conflict_stb[i])
    );
  end

  assign qn_o = ~q_o;

  // A clear in the same cycle as a conflict drops that cycle's increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      conflict_cnt_o <= '0;
    end else if ((|conflict_stb) && (conflict_cnt_o != CNT_MAX)) begin
      conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
// Self-checking bench: four conflict-mode instances plus a min-hold/narrow-counter
// instance, all driven from the same stimulus.
module tb_sr_flag_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] s_i, r_i, clr_i;
  logic       clr_cnt;

  logic [4:0][3:0] q_a, qn_a, rise_a, fall_a, conf_a;
  logic [3:0][7:0] cnt_m;
  logic [1:0]      cnt_h;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    sr_flag_bank #(.N_CH(4), .CONFLICT_MODE(g), .MIN_HOLD(0), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .s_i(s_i), .r_i(r_i), .clr_conflict_i(clr_i),
      .clr_cnt_i(clr_cnt), .q_o(q_a[g]), .qn_o(qn_a[g]), .rise_o(rise_a[g]),
      .fall_o(fall_a[g]), .conflict_o(conf_a[g]), .conflict_cnt_o(cnt_m[g])
    );
  end

  sr_flag_bank #(.N_CH(4), .CONFLICT_MODE(0), .MIN_HOLD(3), .CNT_W(2)) u_hold (
    .clk(clk), .rst_n(rst_n), .s_i(s_i), .r_i(r_i), .clr_conflict_i(clr_i),
    .clr_cnt_i(clr_cnt), .q_o(q_a[4]), .qn_o(qn_a[4]), .rise_o(rise_a[4]),
    .fall_o(fall_a[4]), .conflict_o(conf_a[4]), .conflict_cnt_o(cnt_h)
  );

  typedef struct {
    string      tag;
    int         inst;
    logic [3:0] q, rise, fall, conf;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic       rn;
    logic [3:0] s, r, clr;
    logic       cc;
    logic [3:0] q, rise, fall, conf;
    logic [7:0] cnt;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [7:0] cnt_of(input int inst);
    if (inst < 4) return cnt_m[inst];
    return {6'b0, cnt_h};
  endfunction

  task automatic cmp(input string tag, input string field, input logic [7:0] act,
                     input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s.%s actual=%0h required=%0h", tag, field, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.tag, "q",    {4'b0, q_a[e.inst]},    {4'b0, e.q});
      cmp(e.tag, "qn",   {4'b0, qn_a[e.inst]},   {4'b0, ~e.q});
      cmp(e.tag, "rise", {4'b0, rise_a[e.inst]}, {4'b0, e.rise});
      cmp(e.tag, "fall", {4'b0, fall_a[e.inst]}, {4'b0, e.fall});
      cmp(e.tag, "conf", {4'b0, conf_a[e.inst]}, {4'b0, e.conf});
      cmp(e.tag, "cnt",  cnt_of(e.inst),         e.cnt);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic [3:0] s, input logic [3:0] r,
                               input logic [3:0] clr, input logic cc);
    rst_n = rn; s_i = s; r_i = r; clr_i = clr; clr_cnt = cc;
  endtask

  task automatic expectOut(input string tag, input int inst, input logic [3:0] q,
                           input logic [3:0] rise, input logic [3:0] fall,
                           input logic [3:0] conf, input logic [7:0] cnt);
    exp_t e;
    e.tag = tag; e.inst = inst; e.q = q; e.rise = rise; e.fall = fall;
    e.conf = conf; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t tbl[8];

  initial begin
    //           rn    s     r     clr   cc    q     rise  fall  conf  cnt
    tbl[0] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0};
    tbl[1] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0};
    tbl[2] = '{1'b1, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 8'd0};
    tbl[3] = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 8'd0};
    tbl[4] = '{1'b1, 4'h0, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 8'd0};
    tbl[5] = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0};
    tbl[6] = '{1'b1, 4'h3, 4'h0, 4'h0, 1'b0, 4'h3, 4'h3, 4'h0, 4'h0, 8'd0};
    tbl[7] = '{1'b1, 4'h1, 4'h2, 4'h0, 1'b0, 4'h1, 4'h0, 4'h2, 4'h0, 8'd0};

    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].rn, tbl[i].s, tbl[i].r, tbl[i].clr, tbl[i].cc);
      expectOut($sformatf("basic%0d", i), 0, tbl[i].q, tbl[i].rise, tbl[i].fall,
                tbl[i].conf, tbl[i].cnt);
      tick();
    end

    // Conflict policies, then back-to-back toggles
    doReset();
    applyStimulus(1'b1, 4'h2, 4'h0, 4'h0, 1'b0);
    for (int m = 0; m < 4; m++) expectOut($sformatf("mset%0d", m), m, 4'h2, 4'h2, 4'h0, 4'h0, 8'd0);
    tick();
    applyStimulus(1'b1, 4'h2, 4'h2, 4'h0, 1'b0);
    expectOut("mode0", 0, 4'h0, 4'h0, 4'h2, 4'h2, 8'd1);
    expectOut("mode1", 1, 4'h2, 4'h0, 4'h0, 4'h2, 8'd1);
    expectOut("mode2", 2, 4'h2, 4'h0, 4'h0, 4'h2, 8'd1);
    expectOut("mode3", 3, 4'h0, 4'h0, 4'h2, 4'h2, 8'd1);
    tick();
    expectOut("mode0b", 0, 4'h0, 4'h0, 4'h0, 4'h2, 8'd2);
    expectOut("tog1", 3, 4'h2, 4'h2, 4'h0, 4'h2, 8'd2);
    tick();
    expectOut("tog2", 3, 4'h0, 4'h0, 4'h2, 4'h2, 8'd3);
    tick();

    // Min-hold: reset deferred until the hold window closes
    doReset();
    applyStimulus(1'b1, 4'h4, 4'h0, 4'h0, 1'b0);
    expectOut("hold_t1", 4, 4'h4, 4'h4, 4'h0, 4'h0, 8'd0);
    tick();
    applyStimulus(1'b1, 4'h0, 4'h4, 4'h0, 1'b0);
    expectOut("hold_t2", 4, 4'h4, 4'h0, 4'h0, 4'h0, 8'd0);
    tick();
    applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int t = 3; t <= 4; t++) begin
      expectOut($sformatf("hold_t%0d", t), 4, 4'h4, 4'h0, 4'h0, 4'h0, 8'd0);
      tick();
    end
    expectOut("hold_t5", 4, 4'h0, 4'h0, 4'h4, 4'h0, 8'd0);
    tick();
    expectOut("hold_t6", 4, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
    tick();

    // Min-hold: a later set cancels the pending reset
    doReset();
    applyStimulus(1'b1, 4'h4, 4'h0, 4'h0, 1'b0);
    expectOut("cancel_t1", 4, 4'h4, 4'h4, 4'h0, 4'h0, 8'd0);
    tick();
    applyStimulus(1'b1, 4'h0, 4'h4, 4'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h4, 4'h0, 4'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int t = 4; t <= 7; t++) begin
      expectOut($sformatf("cancel_t%0d", t), 4, 4'h4, 4'h0, 4'h0, 4'h0, 8'd0);
      tick();
    end

    // Sticky conflict versus clear in the same cycle
    doReset();
    applyStimulus(1'b1, 4'h8, 4'h8, 4'h8, 1'b0);
    expectOut("race", 0, 4'h0, 4'h0, 4'h0, 4'h8, 8'd1);
    tick();
    applyStimulus(1'b1, 4'h0, 4'h0, 4'h8, 1'b0);
    expectOut("clear", 0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1);
    tick();

    // Counter saturation on the 2-bit instance
    doReset();
    applyStimulus(1'b1, 4'h1, 4'h1, 4'h0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      expectOut($sformatf("sat%0d", k), 4, 4'h0, 4'h0, 4'h0, 4'h1, (k < 3) ? 8'(k) : 8'd3);
      if (k == 5) expectOut("wide5", 0, 4'h0, 4'h0, 4'h0, 4'h1, 8'd5);
      tick();
    end
    applyStimulus(1'b1, 4'h1, 4'h1, 4'h0, 1'b1);
    expectOut("clrcnt", 4, 4'h0, 4'h0, 4'h0, 4'h1, 8'd0);
    expectOut("clrcnt_w", 0, 4'h0, 4'h0, 4'h0, 4'h1, 8'd0);
    tick();

    // Reset in the middle of a hold window with a pending reset
    doReset();
    applyStimulus(1'b1, 4'h4, 4'h0, 4'h0, 1'b0);
    expectOut("mid_t1", 4, 4'h4, 4'h4, 4'h0, 4'h0, 8'd0);
    tick();
    applyStimulus(1'b1, 4'hF, 4'hF, 4'h0, 1'b0);
    expectOut("mid_t2", 4, 4'h4, 4'h0, 4'h0, 4'hF, 8'd1);
    tick();
    applyStimulus(1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
    expectOut("mid_rst", 4, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
    tick();
    applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    expectOut("mid_after", 4, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_flag_bank.md
Name: sr_flag_bank

Overview:
- Clocked, parametrised successor of the combinational single-bit SR latch.
- Holds N_CH independent set/reset flags (per-port request/grant/credit-valid flags in the NoC router).
- Adds a configurable set/reset conflict policy, a minimum-hold guard after set, edge pulses, and conflict status/telemetry.
- Outputs are always defined: never X.

Parameters:
- N_CH, 4, number of independent flag channels (≥1).
- CONFLICT_MODE, 0, s&r policy: 0 = reset-dominant, 1 = set-dominant, 2 = hold, 3 = toggle.
- MIN_HOLD, 0, cycles a flag must stay 1 after a 0→1 transition before a reset may take effect; 0 disables the guard.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, synchronous active-low reset.
- s_i, in, N_CH, per-channel set request, active high.
- r_i, in, N_CH, per-channel reset request, active high.
- clr_conflict_i, in, N_CH, clears the matching conflict_o bit.
- clr_cnt_i, in, 1, clears conflict_cnt_o.
- q_o, out, N_CH, flag state (registered).
- qn_o, out, N_CH, always exactly ~q_o.
- rise_o, out, N_CH, one-cycle pulse in the first cycle q_o reads 1 after 0.
- fall_o, out, N_CH, one-cycle pulse in the first cycle q_o reads 0 after 1.
- conflict_o, out, N_CH, sticky: s_i&r_i seen on that channel.
- conflict_cnt_o, out, CNT_W, saturating count of cycles with any conflict.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low. When rst_n=0 at a clock edge, the following all go to 0: q_o, rise_o, fall_o, conflict_o, conflict_cnt_o, hold timers and pend_rst. qn_o is all 1s. Reset overrides every other input in that cycle.
- Latency: one cycle from s_i/r_i to q_o; no combinational path from inputs to outputs.
- hold_busy[i] = (hold_cnt[i] != 0).
- eff_r[i] = (r_i[i] | pend_rst[i]) & ~hold_busy[i].
- Next-state per channel:
  - s & ~eff_r → 1.
  - eff_r & ~s → 0.
  - Neither → hold.
  - s & eff_r → resolved by CONFLICT_MODE: 0 → 0; 1 → 1; 2 → hold; 3 → ~q.
- Min-hold guard (MIN_HOLD>0):
  - On a 0→1 transition, hold_cnt loads MIN_HOLD; it decrements each cycle to 0.
  - r_i asserted while hold_busy sets pend_rst.
  - pend_rst clears when the reset is applied (q goes 0), or when s_i=1 & r_i=0 in a cycle.
  - Net effect: a reset during hold takes effect in the first cycle hold_cnt==0, and q_o falls on the following edge.
  - A set while q=1 does not reload the timer.
  - In toggle mode a 1→0 toggle is also blocked while hold_busy (q holds).
- Conflict detection uses the raw inputs (s_i&r_i), independent of hold state.
  - conflict_o[i] is set the cycle after a conflict.
  - clr_conflict_i[i] clears it; a new conflict in the same cycle wins (bit stays 1).
- conflict_cnt_o increments by 1 per cycle in which any channel conflicts, and saturates at 2^CNT_W-1.
  - clr_cnt_i clears it; a simultaneous increment is dropped (result 0).
- rise_o/fall_o are registered alongside q_o. Back-to-back toggles give alternating pulses every cycle.
- Channels are fully independent except for the shared counter.

Decomposition:
- Package sr_pkg holds:
  - enum conflict_mode_e {CM_RST_DOM, CM_SET_DOM, CM_HOLD, CM_TOGGLE};
  - function resolve(s, r, q, mode) → next q.
- Sub-module sr_flag_chan (one channel):
  - owns q, hold_cnt, pend_rst, rise, fall and the sticky conflict bit;
  - exports a conflict strobe to the parent.
- sr_flag_bank generates N_CH instances and the shared saturating counter.

Test Plan:
- Reset + basic: rst_n=0 for 2 cycles → q_o=0, qn_o=4'hF, counter 0. Then s_i=4'b0001 for 1 cycle → q_o=4'b0001 next edge; rise_o[0] pulses exactly 1 cycle; qn_o=4'b1110.
- Conflict modes: for each CONFLICT_MODE ∈ {0,1,2,3} with q[1]=1, drive s_i[1]=r_i[1]=1 for 1 cycle → q[1] = 0 / 1 / 1 / 0 respectively; conflict_o[1]=1; conflict_cnt_o=1.
- Min-hold (MIN_HOLD=3): set ch2 at cycle 0 (q=1 at 1); r_i[2]=1 at cycle 1 only → q[2] stays 1 through cycle 4, falls at cycle 5, fall_o[2] pulses once. Repeat with s_i[2] at cycle 2 → pending reset cancelled, q stays 1.
- Sticky/clear race: conflict on ch3 while clr_conflict_i[3]=1 → conflict_o[3]=1. Next cycle clr only → conflict_o[3]=0.
- Counter saturation (CNT_W=2): 5 consecutive conflict cycles → conflict_cnt_o=3. clr_cnt_i with a conflict in the same cycle → 0.
- Reset mid-operation: rst_n=0 while hold_cnt=2, pend_rst=1, conflict_o=4'hF → all state cleared next edge; no rise/fall pulse emitted.
